// File: rtl/alu_issue_stage.sv
// Operand-issue stage: buffers A/B/op triples in a small FIFO, evaluates the head
// entry through a combinational alu and holds the result in a valid/ready output register.

module alu (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    output logic [31:0] o_result_c,
    output logic        o_err_c
);

    // Reserved opcodes produce a zero result and raise the error flag.
    always_comb begin
        o_result_c = '0;
        o_err_c    = 1'b0;
        case (i_op)
            3'b000:  o_result_c = i_a + i_b;
            3'b001:  o_result_c = i_a - i_b;
            3'b010:  o_result_c = i_a & i_b;
            3'b011:  o_result_c = i_a | i_b;
            3'b100:  o_result_c = i_a >> i_b[4:0];
            3'b101:  o_result_c = 32'($signed(i_a) >>> i_b[4:0]);
            default: o_err_c    = 1'b1;
        endcase
    end

endmodule

module alu_issue_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned SEQW  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_A,
    input  logic [31:0]     in_B,
    input  logic [2:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_C,
    output logic            out_err,
    output logic [SEQW-1:0] out_seq,
    output logic [AW:0]     occupancy
);

    localparam int unsigned CW = AW + 1;

    logic [31:0]     r_mem_a  [DEPTH];
    logic [31:0]     r_mem_b  [DEPTH];
    logic [2:0]      r_mem_op [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [SEQW-1:0] r_seq_cnt;

    logic            r_out_valid;
    logic [31:0]     r_out_c;
    logic            r_out_err;
    logic [SEQW-1:0] r_out_seq;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_alu_c;
    logic            w_alu_err;

    // Full is derived from the registered count only, so in_ready never depends on out_ready.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = !w_empty && (!r_out_valid || out_ready);

    assign in_ready  = !w_full;
    assign out_valid = r_out_valid;
    assign out_C     = r_out_c;
    assign out_err   = r_out_err;
    assign out_seq   = r_out_seq;
    assign occupancy = r_count;

    alu u_alu (
        .i_a        (r_mem_a[r_rd_ptr]),
        .i_b        (r_mem_b[r_rd_ptr]),
        .i_op       (r_mem_op[r_rd_ptr]),
        .o_result_c (w_alu_c),
        .o_err_c    (w_alu_err)
    );

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_A;
            r_mem_b[r_wr_ptr]  <= in_B;
            r_mem_op[r_wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    // Output register: a pop reloads it, otherwise a taken result empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_err   <= 1'b0;
            r_out_seq   <= '0;
            r_seq_cnt   <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_c     <= w_alu_c;
            r_out_err   <= w_alu_err;
            r_out_seq   <= r_seq_cnt;
            r_seq_cnt   <= r_seq_cnt + SEQW'(1);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
